// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage between EX/MEM and WB.
// Issues loads/stores over a req/ready handshake, stalls upstream while an
// access is outstanding, and registers the MEM/WB bundle for write-back.
module mem_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EXMEM_valid,
    input  logic              EXMEM_mem_read,
    input  logic              EXMEM_mem_write,
    input  logic [2:0]        EXMEM_funct3,
    input  logic [31:0]       EXMEM_alu_result,
    input  logic [31:0]       EXMEM_store_data,
    input  logic [4:0]        EXMEM_write_reg,
    input  logic              EXMEM_register_write,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic [4:0]        MEMWB_write_reg_out,
    output logic [31:0]       MEMWB_reg_write_data,
    output logic              MEMWB_register_write_valid_out,
    output logic              misalign_exc
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;

    logic        is_mem_c;
    logic        misaligned_c;
    logic        illegal_c;
    logic        bad_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte_c;
    logic [15:0] ld_half_c;
    logic [31:0] ld_data_c;

    // Classify the presented op: misaligned or illegal width codes never reach memory.
    always_comb begin
        is_mem_c     = EXMEM_valid && (EXMEM_mem_read || EXMEM_mem_write);
        misaligned_c = 1'b0;
        illegal_c    = 1'b0;
        case (EXMEM_funct3[1:0])
            2'b01:   misaligned_c = EXMEM_alu_result[0];
            2'b10:   misaligned_c = |EXMEM_alu_result[1:0];
            default: misaligned_c = 1'b0;
        endcase
        if (EXMEM_mem_read)
            illegal_c = (EXMEM_funct3 == 3'b011) || (EXMEM_funct3 == 3'b110) ||
                        (EXMEM_funct3 == 3'b111);
        else
            illegal_c = (EXMEM_funct3 > 3'b010);
        bad_c = misaligned_c || illegal_c;
    end

    // Byte-lane steering: enables follow the access width, data is replicated.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = 32'h0;
        case (EXMEM_funct3[1:0])
            2'b00: begin
                be_c    = 4'(4'b0001 << EXMEM_alu_result[1:0]);
                wdata_c = {4{EXMEM_store_data[7:0]}};
            end
            2'b01: begin
                be_c    = EXMEM_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{EXMEM_store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = EXMEM_store_data;
            end
        endcase
        if (!EXMEM_mem_write)
            wdata_c = 32'h0;
    end

    // Load lane select and sign/zero extension from the latched offset.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte_c = dmem_rdata[7:0];
            2'd1:    ld_byte_c = dmem_rdata[15:8];
            2'd2:    ld_byte_c = dmem_rdata[23:16];
            default: ld_byte_c = dmem_rdata[31:24];
        endcase
        ld_half_c = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_data_c = {24'h0, ld_byte_c};
            3'b101:  ld_data_c = {16'h0, ld_half_c};
            default: ld_data_c = dmem_rdata;
        endcase
    end

    // Hold upstream while a legal memory op is presented or the access is pending.
    always_comb begin
        mem_stall = 1'b0;
        if (rst_n) begin
            if (state == S_IDLE)
                mem_stall = is_mem_c && !bad_c;
            else
                mem_stall = !dmem_ready;
        end
    end

    // Stage FSM with registered memory request and MEM/WB bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                          <= S_IDLE;
            off_q                          <= 2'b00;
            f3_q                           <= 3'b000;
            rd_q                           <= 5'd0;
            dmem_req                       <= 1'b0;
            dmem_we                        <= 1'b0;
            dmem_addr                      <= '0;
            dmem_wdata                     <= 32'h0;
            dmem_be                        <= 4'b0000;
            MEMWB_write_reg_out            <= 5'd0;
            MEMWB_reg_write_data           <= 32'h0;
            MEMWB_register_write_valid_out <= 1'b0;
            misalign_exc                   <= 1'b0;
        end else begin
            misalign_exc                   <= 1'b0;
            MEMWB_write_reg_out            <= 5'd0;
            MEMWB_reg_write_data           <= 32'h0;
            MEMWB_register_write_valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (is_mem_c) begin
                        if (bad_c) begin
                            misalign_exc <= 1'b1;
                        end else begin
                            state      <= S_ACCESS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= EXMEM_mem_write;
                            dmem_addr  <= ADDR_W'({EXMEM_alu_result[31:2], 2'b00});
                            dmem_be    <= be_c;
                            dmem_wdata <= wdata_c;
                            f3_q       <= EXMEM_funct3;
                            rd_q       <= EXMEM_write_reg;
                            off_q      <= EXMEM_alu_result[1:0];
                        end
                    end else if (EXMEM_valid) begin
                        MEMWB_write_reg_out            <= EXMEM_write_reg;
                        MEMWB_reg_write_data           <= EXMEM_alu_result;
                        MEMWB_register_write_valid_out <= EXMEM_register_write &&
                                                          (EXMEM_write_reg != 5'd0);
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        state      <= S_IDLE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_be    <= 4'b0000;
                        dmem_wdata <= 32'h0;
                        if (!dmem_we) begin
                            MEMWB_write_reg_out            <= rd_q;
                            MEMWB_reg_write_data           <= ld_data_c;
                            MEMWB_register_write_valid_out <= (rd_q != 5'd0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table plus hand-written multi-cycle sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EXMEM_valid, EXMEM_mem_read, EXMEM_mem_write;
    logic [2:0]  EXMEM_funct3;
    logic [31:0] EXMEM_alu_result, EXMEM_store_data;
    logic [4:0]  EXMEM_write_reg;
    logic        EXMEM_register_write;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [4:0]  MEMWB_write_reg_out;
    logic [31:0] MEMWB_reg_write_data;
    logic        MEMWB_register_write_valid_out;
    logic        misalign_exc;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .EXMEM_valid(EXMEM_valid), .EXMEM_mem_read(EXMEM_mem_read),
        .EXMEM_mem_write(EXMEM_mem_write), .EXMEM_funct3(EXMEM_funct3),
        .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_store_data(EXMEM_store_data),
        .EXMEM_write_reg(EXMEM_write_reg), .EXMEM_register_write(EXMEM_register_write),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .MEMWB_write_reg_out(MEMWB_write_reg_out),
        .MEMWB_reg_write_data(MEMWB_reg_write_data),
        .MEMWB_register_write_valid_out(MEMWB_register_write_valid_out),
        .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rdn, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata;
        logic [4:0]  rd;
        logic        regw;
        int          lat;
        logic [31:0] rdata;
        logic        acc, exc;
        logic [31:0] exp_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        EXMEM_valid = 1'b0; EXMEM_mem_read = 1'b0; EXMEM_mem_write = 1'b0;
        EXMEM_funct3 = 3'b000; EXMEM_alu_result = 32'h0; EXMEM_store_data = 32'h0;
        EXMEM_write_reg = 5'd0; EXMEM_register_write = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic present(input logic rdn, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] rd, input logic regw);
        EXMEM_valid = 1'b1; EXMEM_mem_read = rdn; EXMEM_mem_write = wr;
        EXMEM_funct3 = f3; EXMEM_alu_result = addr; EXMEM_store_data = sdata;
        EXMEM_write_reg = rd; EXMEM_register_write = regw;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        present(v.rdn, v.wr, v.f3, v.addr, v.sdata, v.rd, v.regw);
        EXMEM_valid = v.valid;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        #1 check("stall_present", idx, 32'(mem_stall), 32'(v.acc));
        @(negedge clk);
        if (v.acc) begin
            for (int k = 1; k <= v.lat; k++) begin
                check("req", idx, 32'(dmem_req), 32'd1);
                check("addr", idx, dmem_addr, v.exp_addr);
                check("we", idx, 32'(dmem_we), 32'(v.wr));
                if (v.wr) begin
                    check("be", idx, 32'(dmem_be), 32'(v.be));
                    check("wdata", idx, dmem_wdata, v.wdata);
                end
                check("bubble", idx, 32'(MEMWB_register_write_valid_out), 32'd0);
                if (k == v.lat) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = v.rdata;
                end
                #1 check("stall_access", idx, 32'(mem_stall), 32'(k != v.lat));
                @(negedge clk);
            end
        end
        idle_inputs();
        check("req_after", idx, 32'(dmem_req), 32'd0);
        check("exc", idx, 32'(misalign_exc), 32'(v.exc));
        check("wb_valid", idx, 32'(MEMWB_register_write_valid_out), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check("wb_rd", idx, 32'(MEMWB_write_reg_out), 32'(v.rd));
            check("wb_data", idx, MEMWB_reg_write_data, v.exp_data);
        end
        @(negedge clk);
        check("single_write", idx, 32'(MEMWB_register_write_valid_out), 32'd0);
        check("exc_pulse", idx, 32'(misalign_exc), 32'd0);
    endtask

    initial begin
        //        valid rdn wr f3    addr          sdata          rd    regw lat rdata          acc exc exp_addr     be     wdata          ev  exp_data
        vt[0]  = '{1'b1,1'b0,1'b0,3'd0,32'h0000000F,32'h0,        5'd5, 1'b1,0, 32'h0,        1'b0,1'b0,32'h0,    4'h0,32'h0,        1'b1,32'h0000000F};
        vt[1]  = '{1'b1,1'b0,1'b0,3'd0,32'h0000000F,32'h0,        5'd0, 1'b1,0, 32'h0,        1'b0,1'b0,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[2]  = '{1'b1,1'b1,1'b0,3'd0,32'h00000103,32'h0,        5'd7, 1'b1,3, 32'h80AABBCC, 1'b1,1'b0,32'h100,  4'h0,32'h0,        1'b1,32'hFFFFFF80};
        vt[3]  = '{1'b1,1'b1,1'b0,3'd4,32'h00000103,32'h0,        5'd7, 1'b1,1, 32'h80AABBCC, 1'b1,1'b0,32'h100,  4'h0,32'h0,        1'b1,32'h00000080};
        vt[4]  = '{1'b1,1'b0,1'b1,3'd1,32'h00000202,32'h1234ABCD, 5'd0, 1'b0,2, 32'h0,        1'b1,1'b0,32'h200,  4'hC,32'hABCDABCD, 1'b0,32'h0};
        vt[5]  = '{1'b1,1'b1,1'b0,3'd2,32'h00000105,32'h0,        5'd4, 1'b1,0, 32'h0,        1'b0,1'b1,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[6]  = '{1'b1,1'b1,1'b0,3'd1,32'h00000102,32'h0,        5'd8, 1'b1,1, 32'h80AABBCC, 1'b1,1'b0,32'h100,  4'h0,32'h0,        1'b1,32'hFFFF80AA};
        vt[7]  = '{1'b1,1'b1,1'b0,3'd5,32'h00000100,32'h0,        5'd9, 1'b1,1, 32'h80AABBCC, 1'b1,1'b0,32'h100,  4'h0,32'h0,        1'b1,32'h0000BBCC};
        vt[8]  = '{1'b1,1'b0,1'b1,3'd0,32'h00000001,32'h123456A5, 5'd0, 1'b0,1, 32'h0,        1'b1,1'b0,32'h0,    4'h2,32'hA5A5A5A5, 1'b0,32'h0};
        vt[9]  = '{1'b1,1'b1,1'b0,3'd1,32'h00000101,32'h0,        5'd6, 1'b1,0, 32'h0,        1'b0,1'b1,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[10] = '{1'b1,1'b1,1'b0,3'd3,32'h00000000,32'h0,        5'd6, 1'b1,0, 32'h0,        1'b0,1'b1,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[11] = '{1'b1,1'b0,1'b1,3'd3,32'h00000000,32'h55,       5'd0, 1'b0,0, 32'h0,        1'b0,1'b1,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[12] = '{1'b1,1'b1,1'b0,3'd2,32'h00000008,32'h0,        5'd0, 1'b1,1, 32'h11223344, 1'b1,1'b0,32'h8,    4'h0,32'h0,        1'b0,32'h0};
        vt[13] = '{1'b1,1'b1,1'b0,3'd0,32'h00000101,32'h0,        5'd10,1'b1,1, 32'h80AABBCC, 1'b1,1'b0,32'h100,  4'h0,32'h0,        1'b1,32'hFFFFFFBB};
        vt[14] = '{1'b0,1'b1,1'b0,3'd2,32'h00000010,32'h0,        5'd3, 1'b1,0, 32'h0,        1'b0,1'b0,32'h0,    4'h0,32'h0,        1'b0,32'h0};
        vt[15] = '{1'b1,1'b0,1'b1,3'd2,32'h00000020,32'hCAFEF00D, 5'd0, 1'b0,1, 32'h0,        1'b1,1'b0,32'h20,   4'hF,32'hCAFEF00D, 1'b0,32'h0};
        vt[16] = '{1'b1,1'b1,1'b0,3'd2,32'h00000024,32'h0,        5'd11,1'b1,2, 32'h0BADF00D, 1'b1,1'b0,32'h24,   4'h0,32'h0,        1'b1,32'h0BADF00D};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("reset_req", 0, 32'(dmem_req), 32'd0);
        check("reset_valid", 0, 32'(MEMWB_register_write_valid_out), 32'd0);
        check("reset_data", 0, MEMWB_reg_write_data, 32'h0);
        check("reset_exc", 0, 32'(misalign_exc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            apply(vt[i], i);

        // Back-to-back SW then LW to the same word, each ready in its first ACCESS cycle.
        @(negedge clk);
        present(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
        #1 check("b2b_sw_stall", 100, 32'(mem_stall), 32'd1);
        @(negedge clk);
        check("b2b_sw_req", 100, 32'(dmem_req), 32'd1);
        check("b2b_sw_we", 100, 32'(dmem_we), 32'd1);
        check("b2b_sw_addr", 100, dmem_addr, 32'h10);
        check("b2b_sw_wdata", 100, dmem_wdata, 32'hDEADBEEF);
        dmem_ready = 1'b1;
        #1 check("b2b_sw_go", 100, 32'(mem_stall), 32'd0);
        @(negedge clk);
        present(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 5'd12, 1'b1);
        dmem_ready = 1'b0;
        #1 check("b2b_lw_stall", 101, 32'(mem_stall), 32'd1);
        check("b2b_gap_req", 101, 32'(dmem_req), 32'd0);
        check("b2b_sw_nowb", 101, 32'(MEMWB_register_write_valid_out), 32'd0);
        @(negedge clk);
        check("b2b_lw_req", 101, 32'(dmem_req), 32'd1);
        check("b2b_lw_we", 101, 32'(dmem_we), 32'd0);
        check("b2b_lw_addr", 101, dmem_addr, 32'h10);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        idle_inputs();
        check("b2b_lw_valid", 101, 32'(MEMWB_register_write_valid_out), 32'd1);
        check("b2b_lw_rd", 101, 32'(MEMWB_write_reg_out), 32'd12);
        check("b2b_lw_data", 101, MEMWB_reg_write_data, 32'hDEADBEEF);

        // Reset while an access is outstanding, then a normal ALU op.
        @(negedge clk);
        present(1'b1, 1'b0, 3'd0, 32'h40, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        check("rst_pre_req", 102, 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req", 102, 32'(dmem_req), 32'd0);
        check("rst_stall", 102, 32'(mem_stall), 32'd0);
        check("rst_addr", 102, dmem_addr, 32'h0);
        check("rst_valid", 102, 32'(MEMWB_register_write_valid_out), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_held_req", 102, 32'(dmem_req), 32'd0);
        present(1'b0, 1'b0, 3'd0, 32'h00001234, 32'h0, 5'd9, 1'b1);
        #1 check("rst_alu_stall", 103, 32'(mem_stall), 32'd0);
        @(negedge clk);
        idle_inputs();
        check("rst_alu_valid", 103, 32'(MEMWB_register_write_valid_out), 32'd1);
        check("rst_alu_rd", 103, 32'(MEMWB_write_reg_out), 32'd9);
        check("rst_alu_data", 103, MEMWB_reg_write_data, 32'h00001234);
        check("rst_alu_req", 103, 32'(dmem_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
